gray_decoder_nbits: RTL and testbench

//  Receive end of the N-bit Gray counter bus: samples a Gray code arriving from another clock domain, decodes it to binary and checks count integrity.
//  - Synchronizes, converts and checks that each update is a legal +1 (or hold).
//  - Flags wrap, illegal jumps and stalls.
//  - Sits between a gray counter output and local binary consumers (pointers, timestamps).

---
 rtl/gray_decoder_nbits_pkg.sv | 26 ++
 rtl/gray_decoder_nbits_if.sv | 33 +++
 rtl/gray_decoder_nbits_sync.sv | 39 +++
 rtl/gray_decoder_nbits.sv | 150 +++++++++++++++
 tb/tb_gray_decoder_nbits.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/gray_decoder_nbits_pkg.sv
// Shared types and helpers for the Gray-code receive decoder.
//   state_e   : decoder FSM states (ACQ = acquiring, TRACK = following the count)
//   ST_W      : width of the state encoding
//   gray2bin  : Gray -> binary conversion on a GRAY_MAX_W-bit word; callers
//               zero-extend their N-bit code and truncate the result back to N.
package gray_dec_pkg;

  localparam int unsigned ST_W       = 1;
  localparam int unsigned GRAY_MAX_W = 32;

  typedef enum logic [ST_W-1:0] {
    ACQ   = 1'b0,
    TRACK = 1'b1
  } state_e;

  // Leading zeros from zero-extension leave the low bits of the result unchanged.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_decoder_nbits_if.sv
// Bus between a Gray-code source side (master) and the decoder (slave).
//   clk_en    : decode/check stage update enable (master -> slave)
//   gray_in   : N-bit Gray code from the remote counter (master -> slave)
//   bin_out   : decoded binary value
//   step/wrap/err : one-cycle event pulses
//   stalled/locked: status levels
//   err_count : saturating error count (zero when the counter is not built)
interface gray_decoder_nbits_if #(
  parameter int unsigned N        = 4,
  parameter int unsigned ERRCNT_W = 8
);

  logic                clk_en;
  logic [N-1:0]        gray_in;
  logic [N-1:0]        bin_out;
  logic                step;
  logic                wrap;
  logic                err;
  logic                stalled;
  logic                locked;
  logic [ERRCNT_W-1:0] err_count;

  modport master (
    output clk_en, gray_in,
    input  bin_out, step, wrap, err, stalled, locked, err_count
  );

  modport slave (
    input  clk_en, gray_in,
    output bin_out, step, wrap, err, stalled, locked, err_count
  );

endinterface

// File: rtl/gray_decoder_nbits_sync.sv
// gray_sync: SYNC_STAGES-deep N-bit synchronizer chain for the incoming Gray code.
//   clk, rst : clock and synchronous active-high reset
//   d        : asynchronous Gray code input
//   q        : synchronized code (last stage)
//   vld      : high once the chain has been refilled with real samples after reset
module gray_sync #(
  parameter int unsigned N           = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d,
  output logic [N-1:0] q,
  output logic         vld
);

  logic [N-1:0]           chain [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] fill;

  // Free-running shift; a parallel marker chain tracks when reset zeros have drained out.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        chain[i] <= '0;
      end
      fill <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
      fill <= {fill[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign q   = chain[SYNC_STAGES-1];
  assign vld = fill[SYNC_STAGES-1];

endmodule

// File: rtl/gray_decoder_nbits.sv
// gray_decoder_nbits: receive end of an N-bit Gray counter bus. Synchronizes the
// remote Gray code, decodes it to binary and checks that each update is +1 or hold.
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-high (priority over everything)
//   bus  : slave side of gray_decoder_nbits_if (clk_en, gray_in in; bin_out,
//          step, wrap, err, stalled, locked, err_count out)
// Optional feature: define GRAY_DEC_ERRCNT_EN to build the saturating error
// counter; otherwise err_count is tied to zero.
module gray_decoder_nbits
  import gray_dec_pkg::*;
#(
  parameter int unsigned N           = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned STALL_LIMIT = 16,
  parameter int unsigned ERRCNT_W    = 8
) (
  input logic               clk,
  input logic               rst,
  gray_decoder_nbits_if.slave bus
);

  localparam int unsigned STALL_W = $clog2(STALL_LIMIT + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);

  logic [N-1:0]       g_s;
  logic               g_vld;
  logic [N-1:0]       b;
  logic [N-1:0]       delta;

  state_e             state_q, state_d;
  logic [N-1:0]       bin_q, bin_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               step_q, step_d;
  logic               wrap_q, wrap_d;
  logic               err_q, err_d;
  logic               stalled_q, stalled_d;
  logic               locked_q, locked_d;

  gray_sync #(
    .N           (N),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.gray_in),
    .q   (g_s),
    .vld (g_vld)
  );

  // Decode and modular distance from the currently held value.
  assign b     = N'(gray2bin(GRAY_MAX_W'(g_s)));
  assign delta = N'(b - bin_q);

  // Next-state and flag logic; pulses default low so they clear on disabled edges.
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    stall_d   = stall_q;
    stalled_d = stalled_q;
    step_d    = 1'b0;
    wrap_d    = 1'b0;
    err_d     = 1'b0;

    if (bus.clk_en) begin
      unique case (state_q)
        ACQ: begin
          // Acquire only once the synchronizer holds a real post-reset sample.
          if (g_vld) begin
            bin_d     = b;
            stall_d   = '0;
            stalled_d = 1'b0;
            state_d   = TRACK;
          end
        end
        TRACK: begin
          if (delta == N'(1)) begin
            bin_d     = b;
            step_d    = 1'b1;
            wrap_d    = (bin_q == '1);
            stall_d   = '0;
            stalled_d = 1'b0;
          end else if (delta == '0) begin
            if (stall_q != STALL_MAX) begin
              stall_d = stall_q + STALL_W'(1);
            end
            stalled_d = (stall_d == STALL_MAX);
          end else begin
            // Adopt the new value; the next enabled edge re-acquires silently.
            bin_d     = b;
            err_d     = 1'b1;
            stall_d   = '0;
            stalled_d = 1'b0;
            state_d   = ACQ;
          end
        end
        default: state_d = ACQ;
      endcase
    end

    locked_d = (state_d == TRACK);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACQ;
      bin_q     <= '0;
      stall_q   <= '0;
      step_q    <= 1'b0;
      wrap_q    <= 1'b0;
      err_q     <= 1'b0;
      stalled_q <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      stall_q   <= stall_d;
      step_q    <= step_d;
      wrap_q    <= wrap_d;
      err_q     <= err_d;
      stalled_q <= stalled_d;
      locked_q  <= locked_d;
    end
  end

`ifdef GRAY_DEC_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_count_q;

  // Saturating error counter, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_q <= '0;
    end else if (err_d && (err_count_q != '1)) begin
      err_count_q <= err_count_q + ERRCNT_W'(1);
    end
  end

  assign bus.err_count = err_count_q;
`else
  assign bus.err_count = ERRCNT_W'(0);
`endif

  assign bus.bin_out = bin_q;
  assign bus.step    = step_q;
  assign bus.wrap    = wrap_q;
  assign bus.err     = err_q;
  assign bus.stalled = stalled_q;
  assign bus.locked  = locked_q;

endmodule

// File: tb/tb_gray_decoder_nbits.sv
// Self-checking bench for gray_decoder_nbits (N=4, SYNC_STAGES=2, STALL_LIMIT=4).
// Directed scenarios plus randomized walks, checked every cycle against a
// behavioural model of the receive path.
module tb_gray_decoder_nbits;

  localparam int unsigned N    = 4;
  localparam int unsigned SYNC = 2;
  localparam int unsigned LIM  = 4;
  localparam int unsigned EW   = 8;
  localparam int          NV   = 1 << N;
  localparam int          ECMAX = (1 << EW) - 1;

  logic clk = 1'b0;
  logic rst;

  gray_decoder_nbits_if #(.N(N), .ERRCNT_W(EW)) bus ();

  gray_decoder_nbits #(
    .N           (N),
    .SYNC_STAGES (SYNC),
    .STALL_LIMIT (LIM),
    .ERRCNT_W    (EW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model state.
  int sh [SYNC];
  int fill;
  int m_bin, m_stall, m_ec;
  bit m_lock, m_step, m_wrap, m_err, m_stalled;

  int cur;
  int n_step, n_wrap, n_err;

  function automatic int gray_of(input int k);
    return k ^ (k >> 1);
  endfunction

  // Inverse by table search over all codes.
  function automatic int bin_of(input int g);
    for (int k = 0; k < NV; k++) begin
      if (gray_of(k) == g) return k;
    end
    return 0;
  endfunction

  function automatic int exp_ec();
`ifdef GRAY_DEC_ERRCNT_EN
    return m_ec;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_edge();
    int gs, b, d;
    bit vld;
    if (rst) begin
      for (int i = 0; i < SYNC; i++) sh[i] = 0;
      fill = 0; m_bin = 0; m_stall = 0; m_ec = 0;
      m_lock = 0; m_step = 0; m_wrap = 0; m_err = 0; m_stalled = 0;
      return;
    end
    gs  = sh[SYNC-1];
    vld = (fill >= SYNC);
    for (int i = SYNC - 1; i > 0; i--) sh[i] = sh[i-1];
    sh[0] = int'(bus.gray_in);
    if (fill < SYNC) fill++;
    m_step = 0; m_wrap = 0; m_err = 0;
    if (bus.clk_en) begin
      b = bin_of(gs);
      if (!m_lock) begin
        if (vld) begin
          m_bin = b; m_lock = 1; m_stall = 0; m_stalled = 0;
        end
      end else begin
        d = (b - m_bin + NV) % NV;
        if (d == 1) begin
          m_step = 1; m_wrap = (m_bin == NV - 1);
          m_bin = b; m_stall = 0; m_stalled = 0;
        end else if (d == 0) begin
          if (m_stall < LIM) m_stall++;
          m_stalled = (m_stall == LIM);
        end else begin
          m_err = 1; m_bin = b; m_stall = 0; m_stalled = 0; m_lock = 0;
          if (m_ec < ECMAX) m_ec++;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".bin"},     32'(bus.bin_out),   32'(m_bin));
    chk({tag, ".step"},    32'(bus.step),      32'(m_step));
    chk({tag, ".wrap"},    32'(bus.wrap),      32'(m_wrap));
    chk({tag, ".err"},     32'(bus.err),       32'(m_err));
    chk({tag, ".stalled"}, 32'(bus.stalled),   32'(m_stalled));
    chk({tag, ".locked"},  32'(bus.locked),    32'(m_lock));
    chk({tag, ".errcnt"},  32'(bus.err_count), 32'(exp_ec()));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
    n_step += int'(bus.step);
    n_wrap += int'(bus.wrap);
    n_err  += int'(bus.err);
  endtask

  task automatic do_reset(input int g);
    rst = 1'b1;
    bus.gray_in = N'(g);
    tick("reset");
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.clk_en = 1'b1;
    bus.gray_in = 4'b0110;
    n_step = 0; n_wrap = 0; n_err = 0;

    // 1: reset with a nonzero code waiting, then acquisition latency.
    repeat (3) tick("rst");
    chk("rst_bin",    32'(bus.bin_out), 32'd0);
    chk("rst_locked", 32'(bus.locked),  32'd0);
    rst = 1'b0;
    tick("acq1");
    tick("acq2");
    chk("acq_wait_locked", 32'(bus.locked), 32'd0);
    tick("acq3");
    chk("acq_bin",    32'(bus.bin_out), 32'h4);
    chk("acq_locked", 32'(bus.locked),  32'd1);

    // 2: full Gray sequence with wrap.
    do_reset(0);
    repeat (3) tick("cnt_lock");
    n_step = 0; n_wrap = 0; n_err = 0;
    for (int k = 1; k <= NV; k++) begin
      bus.gray_in = N'(gray_of(k % NV));
      tick("count");
      tick("count");
    end
    repeat (2) tick("count_tail");
    chk("count_steps", 32'(n_step), 32'(NV));
    chk("count_wraps", 32'(n_wrap), 32'd1);
    chk("count_errs",  32'(n_err),  32'd0);
    chk("count_bin",   32'(bus.bin_out), 32'd0);

    // 3: illegal jump and silent re-acquire.
    do_reset(1);
    repeat (5) tick("jmp_lock");
    chk("jmp_pre_bin", 32'(bus.bin_out), 32'd1);
    bus.gray_in = 4'b0110;
    tick("jmp_a");
    bus.gray_in = 4'b0111;
    tick("jmp_b");
    tick("jmp_c");
    chk("jmp_err",    32'(bus.err),     32'd1);
    chk("jmp_bin",    32'(bus.bin_out), 32'd4);
    chk("jmp_locked", 32'(bus.locked),  32'd0);
    tick("reacq");
    chk("reacq_bin",    32'(bus.bin_out), 32'd5);
    chk("reacq_locked", 32'(bus.locked),  32'd1);
    chk("reacq_step",   32'(bus.step),    32'd0);
`ifdef GRAY_DEC_ERRCNT_EN
    chk("reacq_errcnt", 32'(bus.err_count), 32'd1);
`else
    chk("reacq_errcnt", 32'(bus.err_count), 32'd0);
`endif

    // 4: stall detection and release.
    repeat (3) tick("stall_hold");
    chk("stall_pre", 32'(bus.stalled), 32'd0);
    tick("stall_hold");
    chk("stall_set", 32'(bus.stalled), 32'd1);
    bus.gray_in = N'(gray_of(6));
    tick("stall_rel");
    tick("stall_rel");
    tick("stall_rel");
    chk("stall_clr",  32'(bus.stalled), 32'd0);
    chk("stall_step", 32'(bus.step),    32'd1);
    chk("stall_bin",  32'(bus.bin_out), 32'd6);

    // 5: enable gating.
    do_reset(1);
    repeat (3) tick("gate_lock");
    bus.clk_en = 1'b0;
    bus.gray_in = 4'b0011;
    repeat (5) tick("gate_off");
    chk("gate_off_bin",  32'(bus.bin_out), 32'd1);
    chk("gate_off_step", 32'(bus.step),    32'd0);
    bus.clk_en = 1'b1;
    tick("gate_on");
    chk("gate_on_step", 32'(bus.step),    32'd1);
    chk("gate_on_bin",  32'(bus.bin_out), 32'd2);
    tick("gate_after");
    chk("gate_after_step", 32'(bus.step), 32'd0);

    // Randomized walk: holds, legal steps, occasional jumps, random enable.
    cur = 2;
    for (int i = 0; i < 1500; i++) begin
      int r;
      bus.clk_en = ($urandom_range(0, 3) != 0);
      r = int'($urandom_range(0, 9));
      if (r >= 5 && r <= 8) cur = (cur + 1) % NV;
      else if (r == 9) cur = int'($urandom_range(0, NV - 1));
      bus.gray_in = N'(gray_of(cur));
      tick("rand");
    end

    // 6: error counter saturation with repeated illegal jumps.
    bus.clk_en = 1'b1;
    do_reset(0);
    cur = 0;
    for (int j = 0; j < 300; j++) begin
      int v;
      do v = int'($urandom_range(0, NV - 1));
      while (((v - cur + NV) % NV) <= 1);
      cur = v;
      bus.gray_in = N'(gray_of(cur));
      tick("sat");
      tick("sat");
    end
    repeat (3) tick("sat_tail");
`ifdef GRAY_DEC_ERRCNT_EN
    chk("sat_errcnt", 32'(bus.err_count), 32'(ECMAX));
`else
    chk("sat_errcnt", 32'(bus.err_count), 32'd0);
`endif

    // Mid-operation reset.
    bus.gray_in = N'(gray_of((cur + 5) % NV));
    tick("pre_rst");
    rst = 1'b1;
    tick("mid_rst");
    chk("mid_rst_bin",     32'(bus.bin_out),   32'd0);
    chk("mid_rst_locked",  32'(bus.locked),    32'd0);
    chk("mid_rst_errcnt",  32'(bus.err_count), 32'd0);
    chk("mid_rst_stalled", 32'(bus.stalled),   32'd0);
    rst = 1'b0;
    repeat (4) tick("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
